// File: rtl/z80_flags_pkg.sv
// Shared Z80 flag definitions: F bit positions, condition codes and flag commands.
// Used by the flag register and by any unit that decodes or evaluates conditions.
package z80_flags_pkg;

  localparam int unsigned FLAG_C  = 0;
  localparam int unsigned FLAG_N  = 1;
  localparam int unsigned FLAG_PV = 2;
  localparam int unsigned FLAG_X3 = 3;
  localparam int unsigned FLAG_H  = 4;
  localparam int unsigned FLAG_X5 = 5;
  localparam int unsigned FLAG_Z  = 6;
  localparam int unsigned FLAG_S  = 7;

  typedef enum logic [2:0] {
    CC_NZ = 3'd0,
    CC_Z  = 3'd1,
    CC_NC = 3'd2,
    CC_C  = 3'd3,
    CC_PO = 3'd4,
    CC_PE = 3'd5,
    CC_P  = 3'd6,
    CC_M  = 3'd7
  } cc_e;

  // Encoding 2'b11 is reserved and decodes as no command.
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_SCF  = 2'b01,
    CMD_CCF  = 2'b10
  } flag_cmd_e;

endpackage

// File: rtl/cc_eval.sv
// Combinational Z80 condition-code evaluator over an F value.
// Zero latency, no handshake; also used for RET cc prediction.
module cc_eval
  import z80_flags_pkg::*;
#(
  parameter int unsigned CC_WIDTH = 3
) (
  input  logic [7:0]          f,
  input  logic [CC_WIDTH-1:0] cc_sel,
  output logic                cc_true
);

  always_comb begin
    cc_true = 1'b0;
    case (cc_sel)
      CC_WIDTH'(CC_NZ): cc_true = ~f[FLAG_Z];
      CC_WIDTH'(CC_Z):  cc_true =  f[FLAG_Z];
      CC_WIDTH'(CC_NC): cc_true = ~f[FLAG_C];
      CC_WIDTH'(CC_C):  cc_true =  f[FLAG_C];
      CC_WIDTH'(CC_PO): cc_true = ~f[FLAG_PV];
      CC_WIDTH'(CC_PE): cc_true =  f[FLAG_PV];
      CC_WIDTH'(CC_P):  cc_true = ~f[FLAG_S];
      CC_WIDTH'(CC_M):  cc_true =  f[FLAG_S];
      default:          cc_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_register.sv
// Z80 F / F' register pair with masked ALU updates, POP AF, SCF/CCF, EX AF,AF'.
// Condition queries ack one cycle after cc_req; a request is accepted every cycle, no stall.
module flag_register
  import z80_flags_pkg::*;
#(
  parameter logic [7:0]  RESET_F  = 8'hFF,
  parameter int unsigned CC_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                alu_c,
  input  logic                alu_n,
  input  logic                alu_pv,
  input  logic                alu_h,
  input  logic                alu_s,
  input  logic                alu_z,
  input  logic [1:0]          alu_xy,
  input  logic                flag_we,
  input  logic [7:0]          flag_mask,
  input  logic                f_load,
  input  logic [7:0]          f_load_data,
  input  logic [1:0]          flag_cmd,
  input  logic                ex_af,
  input  logic                cc_req,
  input  logic [CC_WIDTH-1:0] cc_sel,
  output logic                cc_ack,
  output logic                cc_true,
  output logic [7:0]          f_out,
  output logic [7:0]          f_alt_out
);

  logic [7:0] f_bank0_q, f_bank0_d;
  logic [7:0] f_bank1_q, f_bank1_d;
  logic       bank_sel_q, bank_sel_d;
  logic       cc_ack_q, cc_ack_d;
  logic       cc_true_q, cc_true_d;

  logic [7:0] alu_vec;
  logic [7:0] f_new;
  logic       eval_true;

  assign alu_vec = {alu_s, alu_z, alu_xy[1], alu_h, alu_xy[0], alu_pv, alu_n, alu_c};

  always_comb begin
    f_out     = bank_sel_q ? f_bank1_q : f_bank0_q;
    f_alt_out = bank_sel_q ? f_bank0_q : f_bank1_q;
  end

  // Query sees the F presented this cycle; same-cycle writes are deliberately not bypassed.
  cc_eval #(.CC_WIDTH(CC_WIDTH)) u_cc_eval (
    .f       (f_out),
    .cc_sel  (cc_sel),
    .cc_true (eval_true)
  );

  always_comb begin
    f_new = f_out;
    if (f_load) begin
      f_new = f_load_data;
    end else if (flag_cmd == CMD_SCF) begin
      f_new[FLAG_C] = 1'b1;
      f_new[FLAG_H] = 1'b0;
      f_new[FLAG_N] = 1'b0;
    end else if (flag_cmd == CMD_CCF) begin
      f_new[FLAG_H] = f_out[FLAG_C];
      f_new[FLAG_C] = ~f_out[FLAG_C];
      f_new[FLAG_N] = 1'b0;
    end else if (flag_we) begin
      f_new = (f_out & ~flag_mask) | (alu_vec & flag_mask);
    end
  end

  // The write targets the pre-swap active bank, so a same-cycle EX AF moves it into F'.
  always_comb begin
    f_bank0_d  = bank_sel_q ? f_bank0_q : f_new;
    f_bank1_d  = bank_sel_q ? f_new     : f_bank1_q;
    bank_sel_d = bank_sel_q ^ ex_af;
    cc_ack_d   = cc_req;
    cc_true_d  = cc_req ? eval_true : cc_true_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      f_bank0_q  <= RESET_F;
      f_bank1_q  <= RESET_F;
      bank_sel_q <= 1'b0;
      cc_ack_q   <= 1'b0;
      cc_true_q  <= 1'b0;
    end else begin
      f_bank0_q  <= f_bank0_d;
      f_bank1_q  <= f_bank1_d;
      bank_sel_q <= bank_sel_d;
      cc_ack_q   <= cc_ack_d;
      cc_true_q  <= cc_true_d;
    end
  end

  assign cc_ack  = cc_ack_q;
  assign cc_true = cc_true_q;

endmodule

// File: tb/tb_flag_register.sv
// Directed bench for flag_register: reset, masked writes, SCF/CCF, priority, EX AF, condition codes.
module tb_flag_register;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alu_c, alu_n, alu_pv, alu_h, alu_s, alu_z;
  logic [1:0] alu_xy;
  logic       flag_we;
  logic [7:0] flag_mask;
  logic       f_load;
  logic [7:0] f_load_data;
  logic [1:0] flag_cmd;
  logic       ex_af;
  logic       cc_req;
  logic [2:0] cc_sel;
  logic       cc_ack;
  logic       cc_true;
  logic [7:0] f_out;
  logic [7:0] f_alt_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_register #(.RESET_F(8'hFF), .CC_WIDTH(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alu_c       (alu_c),
    .alu_n       (alu_n),
    .alu_pv      (alu_pv),
    .alu_h       (alu_h),
    .alu_s       (alu_s),
    .alu_z       (alu_z),
    .alu_xy      (alu_xy),
    .flag_we     (flag_we),
    .flag_mask   (flag_mask),
    .f_load      (f_load),
    .f_load_data (f_load_data),
    .flag_cmd    (flag_cmd),
    .ex_af       (ex_af),
    .cc_req      (cc_req),
    .cc_sel      (cc_sel),
    .cc_ack      (cc_ack),
    .cc_true     (cc_true),
    .f_out       (f_out),
    .f_alt_out   (f_alt_out)
  );

  task automatic idle();
    flag_we = 1'b0; flag_mask = 8'h00; f_load = 1'b0; f_load_data = 8'h00;
    flag_cmd = 2'b00; ex_af = 1'b0; cc_req = 1'b0; cc_sel = 3'd0;
    {alu_s, alu_z, alu_h, alu_pv, alu_n, alu_c} = 6'b0;
    alu_xy = 2'b00;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_f(input logic [7:0] v);
    idle();
    f_load = 1'b1; f_load_data = v;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    cc_req = 1'b1; cc_sel = 3'd1;
    tick(); tick();
    checks++; if (f_out !== 8'hFF) begin errors++; $display("FAIL reset_f_out got %h exp ff", f_out); end
    checks++; if (f_alt_out !== 8'hFF) begin errors++; $display("FAIL reset_f_alt got %h exp ff", f_alt_out); end
    checks++; if (cc_ack !== 1'b0) begin errors++; $display("FAIL reset_cc_ack got %b exp 0", cc_ack); end
    checks++; if (cc_true !== 1'b0) begin errors++; $display("FAIL reset_cc_true got %b exp 0", cc_true); end
    reset_n = 1'b1;
    cc_req = 1'b1; cc_sel = 3'd1;
    tick();
    checks++; if (cc_ack !== 1'b1) begin errors++; $display("FAIL post_reset_ack got %b exp 1", cc_ack); end
    checks++; if (cc_true !== 1'b1) begin errors++; $display("FAIL post_reset_z got %b exp 1", cc_true); end
    idle();
    tick();
    checks++; if (cc_ack !== 1'b0) begin errors++; $display("FAIL ack_drop got %b exp 0", cc_ack); end
    checks++; if (cc_true !== 1'b1) begin errors++; $display("FAIL cc_true_hold got %b exp 1", cc_true); end
  endtask

  task automatic test_masked_update();
    load_f(8'h00);
    checks++; if (f_out !== 8'h00) begin errors++; $display("FAIL load_00 got %h exp 00", f_out); end
    flag_we = 1'b1; flag_mask = 8'h41;
    {alu_s, alu_z, alu_h, alu_pv, alu_n, alu_c} = 6'b111111; alu_xy = 2'b11;
    tick();
    checks++; if (f_out !== 8'h41) begin errors++; $display("FAIL mask_41 got %h exp 41", f_out); end
    idle();
    flag_we = 1'b1; flag_mask = 8'h00;
    {alu_s, alu_z, alu_h, alu_pv, alu_n, alu_c} = 6'b111111; alu_xy = 2'b11;
    tick();
    checks++; if (f_out !== 8'h41) begin errors++; $display("FAIL mask_zero got %h exp 41", f_out); end
    idle();
    // s=1 z=0 xy=01 h=1 pv=0 n=1 c=0 -> 1001_1010
    flag_we = 1'b1; flag_mask = 8'hFF;
    alu_s = 1'b1; alu_z = 1'b0; alu_xy = 2'b01; alu_h = 1'b1; alu_pv = 1'b0; alu_n = 1'b1; alu_c = 1'b0;
    tick();
    checks++; if (f_out !== 8'h9A) begin errors++; $display("FAIL mask_ff got %h exp 9a", f_out); end
    idle();
  endtask

  task automatic test_scf_ccf();
    load_f(8'h12);
    flag_cmd = 2'b10; tick(); idle();
    checks++; if (f_out !== 8'h01) begin errors++; $display("FAIL ccf1 got %h exp 01", f_out); end
    flag_cmd = 2'b10; tick(); idle();
    checks++; if (f_out !== 8'h10) begin errors++; $display("FAIL ccf2 got %h exp 10", f_out); end
    flag_cmd = 2'b01; tick(); idle();
    checks++; if (f_out !== 8'h01) begin errors++; $display("FAIL scf got %h exp 01", f_out); end
    load_f(8'hEA);
    flag_cmd = 2'b01; tick(); idle();
    checks++; if (f_out !== 8'hE9) begin errors++; $display("FAIL scf_keep got %h exp e9", f_out); end
    load_f(8'h00);
    flag_cmd = 2'b11; tick(); idle();
    checks++; if (f_out !== 8'h00) begin errors++; $display("FAIL rsvd_noop got %h exp 00", f_out); end
    flag_cmd = 2'b11; flag_we = 1'b1; flag_mask = 8'h01; alu_c = 1'b1;
    tick(); idle();
    checks++; if (f_out !== 8'h01) begin errors++; $display("FAIL rsvd_we got %h exp 01", f_out); end
  endtask

  task automatic test_priority();
    f_load = 1'b1; f_load_data = 8'hA5; flag_cmd = 2'b01; flag_we = 1'b1; flag_mask = 8'hFF;
    tick(); idle();
    checks++; if (f_out !== 8'hA5) begin errors++; $display("FAIL prio_load got %h exp a5", f_out); end
    flag_cmd = 2'b10; flag_we = 1'b1; flag_mask = 8'hFF;
    tick(); idle();
    checks++; if (f_out !== 8'hB4) begin errors++; $display("FAIL prio_ccf got %h exp b4", f_out); end
  endtask

  task automatic test_ex_af();
    load_f(8'h80);
    checks++; if (f_out !== 8'h80) begin errors++; $display("FAIL exaf_pre got %h exp 80", f_out); end
    ex_af = 1'b1; f_load = 1'b1; f_load_data = 8'h3C;
    tick(); idle();
    checks++; if (f_out !== 8'hFF) begin errors++; $display("FAIL exaf_f got %h exp ff", f_out); end
    checks++; if (f_alt_out !== 8'h3C) begin errors++; $display("FAIL exaf_alt got %h exp 3c", f_alt_out); end
    ex_af = 1'b1;
    tick(); idle();
    checks++; if (f_out !== 8'h3C) begin errors++; $display("FAIL exaf_back got %h exp 3c", f_out); end
    checks++; if (f_alt_out !== 8'hFF) begin errors++; $display("FAIL exaf_back_alt got %h exp ff", f_alt_out); end
  endtask

  task automatic test_cc_sweep();
    logic [7:0] exp_tbl;
    exp_tbl = 8'b1010_0101; // bit i = expected result for cc_sel i with F=84
    load_f(8'h84);
    for (int i = 0; i < 8; i++) begin
      cc_req = 1'b1; cc_sel = 3'(i);
      tick();
      checks++; if (cc_ack !== 1'b1) begin errors++; $display("FAIL sweep_ack[%0d] got %b exp 1", i, cc_ack); end
      checks++; if (cc_true !== exp_tbl[i]) begin errors++; $display("FAIL sweep_cc[%0d] got %b exp %b", i, cc_true, exp_tbl[i]); end
    end
    idle();
    tick();
    checks++; if (cc_ack !== 1'b0) begin errors++; $display("FAIL sweep_end_ack got %b exp 0", cc_ack); end
    cc_req = 1'b1; cc_sel = 3'd1; flag_we = 1'b1; flag_mask = 8'h40; alu_z = 1'b1;
    tick(); idle();
    checks++; if (cc_true !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", cc_true); end
    checks++; if (f_out !== 8'hC4) begin errors++; $display("FAIL no_bypass_f got %h exp c4", f_out); end
    cc_req = 1'b1; cc_sel = 3'd1;
    tick(); idle();
    checks++; if (cc_true !== 1'b1) begin errors++; $display("FAIL after_write_z got %b exp 1", cc_true); end
  endtask

  task automatic test_reset_mid_query();
    ex_af = 1'b1; f_load = 1'b1; f_load_data = 8'h00;
    tick(); idle();
    cc_req = 1'b1; cc_sel = 3'd0; reset_n = 1'b0;
    tick();
    checks++; if (cc_ack !== 1'b0) begin errors++; $display("FAIL midq_ack got %b exp 0", cc_ack); end
    checks++; if (f_alt_out !== 8'hFF) begin errors++; $display("FAIL midq_alt got %h exp ff", f_alt_out); end
    reset_n = 1'b1; idle();
    load_f(8'h5A);
    ex_af = 1'b1; tick(); idle();
    checks++; if (f_alt_out !== 8'h5A) begin errors++; $display("FAIL midq_bank got %h exp 5a", f_alt_out); end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    test_reset();
    test_masked_update();
    test_scf_ccf();
    test_priority();
    test_ex_af();
    test_cc_sweep();
    test_reset_mid_query();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
